// File: rtl/int_writeback_stage.sv
// Integer writeback stage: picks one register-file write per cycle, resolves rollbacks
// (the older dd stage beats ix), raises traps and squashes each thread's post-rollback shadow.
module int_writeback_stage #(
    parameter int NUM_THREADS     = 4,
    parameter int NUM_LANES       = 16,
    parameter int ROLLBACK_SHADOW = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ix_instruction_valid,
    input  logic [$clog2(NUM_THREADS)-1:0]   ix_thread_idx,
    input  logic                             ix_has_dest,
    input  logic [4:0]                       ix_dest_reg,
    input  logic                             ix_dest_vector,
    input  logic                             ix_is_call,
    input  logic [31:0]                      ix_pc,
    input  logic [32*NUM_LANES-1:0]          ix_result,
    input  logic [NUM_LANES-1:0]             ix_mask_value,
    input  logic                             ix_rollback_en,
    input  logic [31:0]                      ix_rollback_pc,
    input  logic                             ix_privileged_op_fault,
    input  logic                             dd_instruction_valid,
    input  logic [$clog2(NUM_THREADS)-1:0]   dd_thread_idx,
    input  logic                             dd_has_dest,
    input  logic [4:0]                       dd_dest_reg,
    input  logic                             dd_dest_vector,
    input  logic [31:0]                      dd_pc,
    input  logic [32*NUM_LANES-1:0]          dd_result,
    input  logic [NUM_LANES-1:0]             dd_mask_value,
    input  logic                             dd_rollback_en,
    input  logic [31:0]                      dd_rollback_pc,
    input  logic                             dd_fault,
    input  logic [31:0]                      cr_trap_handler,
    output logic                             wb_writeback_en,
    output logic [$clog2(NUM_THREADS)-1:0]   wb_writeback_thread_idx,
    output logic [4:0]                       wb_writeback_reg,
    output logic                             wb_writeback_vector,
    output logic [32*NUM_LANES-1:0]          wb_writeback_value,
    output logic [NUM_LANES-1:0]             wb_writeback_mask,
    output logic                             wb_rollback_en,
    output logic [$clog2(NUM_THREADS)-1:0]   wb_rollback_thread_idx,
    output logic [31:0]                      wb_rollback_pc,
    output logic                             wb_trap,
    output logic [1:0]                       wb_trap_cause,
    output logic [31:0]                      wb_trap_pc,
    output logic                             wb_perf_instruction_retire
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int VW = 32 * NUM_LANES;
    localparam logic [2:0] SHADOW_INIT = 3'(ROLLBACK_SHADOW);

    logic                 writeback_en_q, writeback_en_d;
    logic [TW-1:0]        writeback_thread_idx_q, writeback_thread_idx_d;
    logic [4:0]           writeback_reg_q, writeback_reg_d;
    logic                 writeback_vector_q, writeback_vector_d;
    logic [VW-1:0]        writeback_value_q, writeback_value_d;
    logic [NUM_LANES-1:0] writeback_mask_q, writeback_mask_d;
    logic                 rollback_en_q, rollback_en_d;
    logic [TW-1:0]        rollback_thread_idx_q, rollback_thread_idx_d;
    logic [31:0]          rollback_pc_q, rollback_pc_d;
    logic                 trap_q, trap_d;
    logic [1:0]           trap_cause_q, trap_cause_d;
    logic [31:0]          trap_pc_q, trap_pc_d;
    logic                 retire_q, retire_d;

    logic [NUM_THREADS-1:0] shadow_busy;
    logic [VW-1:0]          ix_scalar_rep, dd_scalar_rep, link_rep;
    logic [31:0]            link_pc;
    logic                   dd_blocked, ix_blocked, dd_live, dd_kill;
    logic                   ix_live, ix_ok, ix_wr, ix_rb_req, dd_wr;

    assign link_pc = ix_pc + 32'd4;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign ix_scalar_rep[gi*32 +: 32] = ix_result[31:0];
            assign dd_scalar_rep[gi*32 +: 32] = dd_result[31:0];
            assign link_rep[gi*32 +: 32]      = link_pc;
        end

        // Each thread's shadow counter reloads on its own rollback and otherwise drains to 0.
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_shadow
            logic [2:0] shadow_q, shadow_d;

            always_comb begin
                shadow_d = shadow_q;
                if (rollback_en_d && rollback_thread_idx_d == TW'(gi))
                    shadow_d = SHADOW_INIT;
                else if (shadow_q != 3'd0)
                    shadow_d = shadow_q - 3'd1;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) shadow_q <= 3'd0;
                else       shadow_q <= shadow_d;
            end

            assign shadow_busy[gi] = (shadow_q != 3'd0);
        end
    endgenerate

    assign dd_blocked = shadow_busy[dd_thread_idx] ||
                        (rollback_en_q && rollback_thread_idx_q == dd_thread_idx);
    assign ix_blocked = shadow_busy[ix_thread_idx] ||
                        (rollback_en_q && rollback_thread_idx_q == ix_thread_idx);
    assign dd_live    = dd_instruction_valid && !dd_blocked;
    assign dd_kill    = dd_live && (dd_fault || dd_rollback_en);
    // dd is older, so its flush also removes the younger ix instruction of the same thread.
    assign ix_live    = ix_instruction_valid && !ix_blocked &&
                        !(dd_kill && dd_thread_idx == ix_thread_idx);
    assign dd_wr      = dd_live && !dd_fault && !dd_rollback_en && dd_has_dest;
    assign ix_ok      = ix_live && !ix_privileged_op_fault;
    assign ix_wr      = ix_ok && (ix_has_dest || ix_is_call);
    assign ix_rb_req  = ix_live && (ix_privileged_op_fault || ix_rollback_en || ix_is_call);

    always_comb begin
        writeback_en_d         = 1'b0;
        writeback_thread_idx_d = '0;
        writeback_reg_d        = 5'd0;
        writeback_vector_d     = 1'b0;
        writeback_value_d      = '0;
        writeback_mask_d       = '0;
        rollback_en_d          = 1'b0;
        rollback_thread_idx_d  = '0;
        rollback_pc_d          = 32'd0;
        trap_d                 = 1'b0;
        trap_cause_d           = 2'd0;
        trap_pc_d              = 32'd0;

        if (dd_live && dd_fault) begin
            rollback_en_d         = 1'b1;
            rollback_thread_idx_d = dd_thread_idx;
            rollback_pc_d         = cr_trap_handler;
            trap_d                = 1'b1;
            trap_cause_d          = 2'd2;
            trap_pc_d             = dd_pc;
        end else if (dd_kill) begin
            rollback_en_d         = 1'b1;
            rollback_thread_idx_d = dd_thread_idx;
            rollback_pc_d         = dd_rollback_pc;
        end else if (ix_live && ix_privileged_op_fault) begin
            rollback_en_d         = 1'b1;
            rollback_thread_idx_d = ix_thread_idx;
            rollback_pc_d         = cr_trap_handler;
            trap_d                = 1'b1;
            trap_cause_d          = 2'd1;
            trap_pc_d             = ix_pc;
        end else if (ix_rb_req) begin
            rollback_en_d         = 1'b1;
            rollback_thread_idx_d = ix_thread_idx;
            rollback_pc_d         = ix_rollback_pc;
        end

        if (dd_wr) begin
            writeback_en_d         = 1'b1;
            writeback_thread_idx_d = dd_thread_idx;
            writeback_reg_d        = dd_dest_reg;
            writeback_vector_d     = dd_dest_vector;
            writeback_value_d      = dd_dest_vector ? dd_result : dd_scalar_rep;
            writeback_mask_d       = dd_dest_vector ? dd_mask_value : '1;
        end else if (ix_wr) begin
            writeback_en_d         = 1'b1;
            writeback_thread_idx_d = ix_thread_idx;
            if (ix_is_call) begin
                writeback_reg_d    = 5'd31;
                writeback_value_d  = link_rep;
                writeback_mask_d   = '1;
            end else begin
                writeback_reg_d    = ix_dest_reg;
                writeback_vector_d = ix_dest_vector;
                writeback_value_d  = ix_dest_vector ? ix_result : ix_scalar_rep;
                writeback_mask_d   = ix_dest_vector ? ix_mask_value : '1;
            end
        end

        retire_d = (dd_live && !dd_fault && !dd_rollback_en) || ix_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeback_en_q         <= 1'b0;
            writeback_thread_idx_q <= '0;
            writeback_reg_q        <= 5'd0;
            writeback_vector_q     <= 1'b0;
            writeback_value_q      <= '0;
            writeback_mask_q       <= '0;
            rollback_en_q          <= 1'b0;
            rollback_thread_idx_q  <= '0;
            rollback_pc_q          <= 32'd0;
            trap_q                 <= 1'b0;
            trap_cause_q           <= 2'd0;
            trap_pc_q              <= 32'd0;
            retire_q               <= 1'b0;
        end else begin
            writeback_en_q         <= writeback_en_d;
            writeback_thread_idx_q <= writeback_thread_idx_d;
            writeback_reg_q        <= writeback_reg_d;
            writeback_vector_q     <= writeback_vector_d;
            writeback_value_q      <= writeback_value_d;
            writeback_mask_q       <= writeback_mask_d;
            rollback_en_q          <= rollback_en_d;
            rollback_thread_idx_q  <= rollback_thread_idx_d;
            rollback_pc_q          <= rollback_pc_d;
            trap_q                 <= trap_d;
            trap_cause_q           <= trap_cause_d;
            trap_pc_q              <= trap_pc_d;
            retire_q               <= retire_d;
        end
    end

    assign wb_writeback_en            = writeback_en_q;
    assign wb_writeback_thread_idx    = writeback_thread_idx_q;
    assign wb_writeback_reg           = writeback_reg_q;
    assign wb_writeback_vector        = writeback_vector_q;
    assign wb_writeback_value         = writeback_value_q;
    assign wb_writeback_mask          = writeback_mask_q;
    assign wb_rollback_en             = rollback_en_q;
    assign wb_rollback_thread_idx     = rollback_thread_idx_q;
    assign wb_rollback_pc             = rollback_pc_q;
    assign wb_trap                    = trap_q;
    assign wb_trap_cause              = trap_cause_q;
    assign wb_trap_pc                 = trap_pc_q;
    assign wb_perf_instruction_retire = retire_q;

    // The scheduler guarantees these never occur; a losing cross-thread rollback would be lost.
    a_one_rollback: assert property (@(posedge clk) disable iff (reset) !(dd_kill && ix_rb_req));
    a_one_write:    assert property (@(posedge clk) disable iff (reset) !(dd_wr && ix_wr));
endmodule

// File: tb/tb_int_writeback_stage.sv
// Bench for int_writeback_stage: directed scenarios with constant expectations, then
// randomized traffic compared against a cycle-indexed behavioural model.
module tb_int_writeback_stage;
    localparam int NT = 4;
    localparam int NL = 16;
    localparam int SH = 2;
    localparam int VW = 32 * NL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ix_instruction_valid, ix_has_dest, ix_dest_vector, ix_is_call;
    logic [1:0]    ix_thread_idx;
    logic [4:0]    ix_dest_reg;
    logic [31:0]   ix_pc, ix_rollback_pc;
    logic [VW-1:0] ix_result;
    logic [NL-1:0] ix_mask_value;
    logic          ix_rollback_en, ix_privileged_op_fault;
    logic          dd_instruction_valid, dd_has_dest, dd_dest_vector;
    logic [1:0]    dd_thread_idx;
    logic [4:0]    dd_dest_reg;
    logic [31:0]   dd_pc, dd_rollback_pc;
    logic [VW-1:0] dd_result;
    logic [NL-1:0] dd_mask_value;
    logic          dd_rollback_en, dd_fault;
    logic [31:0]   cr_trap_handler = 32'h1000;

    logic          wb_writeback_en, wb_writeback_vector, wb_rollback_en, wb_trap;
    logic [1:0]    wb_writeback_thread_idx, wb_rollback_thread_idx, wb_trap_cause;
    logic [4:0]    wb_writeback_reg;
    logic [VW-1:0] wb_writeback_value;
    logic [NL-1:0] wb_writeback_mask;
    logic [31:0]   wb_rollback_pc, wb_trap_pc;
    logic          wb_perf_instruction_retire;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int block_until[NT];

    logic          e_wen, e_wvec, e_rb, e_trap, e_ret;
    logic [1:0]    e_wthr, e_rbthr, e_cause;
    logic [4:0]    e_wreg;
    logic [VW-1:0] e_wval;
    logic [NL-1:0] e_wmask;
    logic [31:0]   e_rbpc, e_tpc;

    int_writeback_stage #(.NUM_THREADS(NT), .NUM_LANES(NL), .ROLLBACK_SHADOW(SH)) dut (
        .clk(clk), .reset(reset),
        .ix_instruction_valid(ix_instruction_valid), .ix_thread_idx(ix_thread_idx),
        .ix_has_dest(ix_has_dest), .ix_dest_reg(ix_dest_reg), .ix_dest_vector(ix_dest_vector),
        .ix_is_call(ix_is_call), .ix_pc(ix_pc), .ix_result(ix_result),
        .ix_mask_value(ix_mask_value), .ix_rollback_en(ix_rollback_en),
        .ix_rollback_pc(ix_rollback_pc), .ix_privileged_op_fault(ix_privileged_op_fault),
        .dd_instruction_valid(dd_instruction_valid), .dd_thread_idx(dd_thread_idx),
        .dd_has_dest(dd_has_dest), .dd_dest_reg(dd_dest_reg), .dd_dest_vector(dd_dest_vector),
        .dd_pc(dd_pc), .dd_result(dd_result), .dd_mask_value(dd_mask_value),
        .dd_rollback_en(dd_rollback_en), .dd_rollback_pc(dd_rollback_pc), .dd_fault(dd_fault),
        .cr_trap_handler(cr_trap_handler),
        .wb_writeback_en(wb_writeback_en), .wb_writeback_thread_idx(wb_writeback_thread_idx),
        .wb_writeback_reg(wb_writeback_reg), .wb_writeback_vector(wb_writeback_vector),
        .wb_writeback_value(wb_writeback_value), .wb_writeback_mask(wb_writeback_mask),
        .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .wb_rollback_pc(wb_rollback_pc), .wb_trap(wb_trap), .wb_trap_cause(wb_trap_cause),
        .wb_trap_pc(wb_trap_pc), .wb_perf_instruction_retire(wb_perf_instruction_retire)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] rep(input logic [31:0] w);
        logic [VW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*32 +: 32] = w;
        return r;
    endfunction

    function automatic logic [95:0] obs_ctrl();
        return {wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg, wb_writeback_vector,
                wb_writeback_mask, wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc,
                wb_trap, wb_trap_cause, wb_trap_pc, wb_perf_instruction_retire};
    endfunction

    function automatic logic [95:0] exp_ctrl();
        return {e_wen, e_wthr, e_wreg, e_wvec, e_wmask, e_rb, e_rbthr, e_rbpc,
                e_trap, e_cause, e_tpc, e_ret};
    endfunction

    task automatic idle();
        ix_instruction_valid = 0; ix_thread_idx = 0; ix_has_dest = 0; ix_dest_reg = 0;
        ix_dest_vector = 0; ix_is_call = 0; ix_pc = 0; ix_result = '0; ix_mask_value = 0;
        ix_rollback_en = 0; ix_rollback_pc = 0; ix_privileged_op_fault = 0;
        dd_instruction_valid = 0; dd_thread_idx = 0; dd_has_dest = 0; dd_dest_reg = 0;
        dd_dest_vector = 0; dd_pc = 0; dd_result = '0; dd_mask_value = 0;
        dd_rollback_en = 0; dd_rollback_pc = 0; dd_fault = 0;
    endtask

    task automatic model_clear();
        for (int t = 0; t < NT; t++) block_until[t] = -1;
    endtask

    // A thread that rolls back at edge c has its inputs discarded at edges c+1 .. c+SH.
    task automatic model_eval();
        logic dd_live, ix_live;
        e_wen = 0; e_wthr = 0; e_wreg = 0; e_wvec = 0; e_wval = '0; e_wmask = 0;
        e_rb = 0; e_rbthr = 0; e_rbpc = 0; e_trap = 0; e_cause = 0; e_tpc = 0; e_ret = 0;
        if (reset) begin
            model_clear();
            return;
        end
        dd_live = dd_instruction_valid && (cyc > block_until[dd_thread_idx]);
        ix_live = ix_instruction_valid && (cyc > block_until[ix_thread_idx]) &&
                  !(dd_live && (dd_fault || dd_rollback_en) && dd_thread_idx == ix_thread_idx);
        if (dd_live && dd_fault) begin
            e_rb = 1; e_rbthr = dd_thread_idx; e_rbpc = cr_trap_handler;
            e_trap = 1; e_cause = 2; e_tpc = dd_pc;
        end else if (dd_live && dd_rollback_en) begin
            e_rb = 1; e_rbthr = dd_thread_idx; e_rbpc = dd_rollback_pc;
        end else if (ix_live && ix_privileged_op_fault) begin
            e_rb = 1; e_rbthr = ix_thread_idx; e_rbpc = cr_trap_handler;
            e_trap = 1; e_cause = 1; e_tpc = ix_pc;
        end else if (ix_live && (ix_rollback_en || ix_is_call)) begin
            e_rb = 1; e_rbthr = ix_thread_idx; e_rbpc = ix_rollback_pc;
        end
        if (dd_live && !dd_fault && !dd_rollback_en && dd_has_dest) begin
            e_wen = 1; e_wthr = dd_thread_idx; e_wreg = dd_dest_reg; e_wvec = dd_dest_vector;
            e_wval = dd_dest_vector ? dd_result : rep(dd_result[31:0]);
            e_wmask = dd_dest_vector ? dd_mask_value : '1;
        end else if (ix_live && !ix_privileged_op_fault && ix_is_call) begin
            e_wen = 1; e_wthr = ix_thread_idx; e_wreg = 31; e_wval = rep(ix_pc + 32'd4);
            e_wmask = '1;
        end else if (ix_live && !ix_privileged_op_fault && ix_has_dest) begin
            e_wen = 1; e_wthr = ix_thread_idx; e_wreg = ix_dest_reg; e_wvec = ix_dest_vector;
            e_wval = ix_dest_vector ? ix_result : rep(ix_result[31:0]);
            e_wmask = ix_dest_vector ? ix_mask_value : '1;
        end
        e_ret = (dd_live && !dd_fault && !dd_rollback_en) || (ix_live && !ix_privileged_op_fault);
        if (e_rb) block_until[e_rbthr] = cyc + SH;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        tick();
        total++;
        if ({obs_ctrl(), wb_writeback_value} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ctrl=%h want all zero", obs_ctrl());
        end
        $display("reset: outputs ctrl=%h", obs_ctrl());
        reset = 0;
        model_clear();
    endtask

    task automatic test_scalar_add();
        idle();
        for (int l = 0; l < NL; l++) ix_result[l*32 +: 32] = $urandom();
        ix_result[31:0] = 32'h1234;
        ix_instruction_valid = 1; ix_thread_idx = 1; ix_has_dest = 1; ix_dest_reg = 5;
        ix_pc = 32'h40;
        tick();
        total++;
        if ({wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg, wb_writeback_vector,
             wb_writeback_mask, wb_perf_instruction_retire, wb_rollback_en, wb_trap} !==
            {1'b1, 2'd1, 5'd5, 1'b0, 16'hffff, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_ctrl got en=%0b thr=%0d reg=%0d mask=%h ret=%0b want 1/1/5/ffff/1",
                     wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg,
                     wb_writeback_mask, wb_perf_instruction_retire);
        end
        total++;
        if (wb_writeback_value !== {16{32'h1234}}) begin
            bad++;
            $display("FAIL add_value got=%h want lanes of 00001234", wb_writeback_value);
        end
        $display("scalar_add: thr=%0d reg=%0d lane0=%h", wb_writeback_thread_idx,
                 wb_writeback_reg, wb_writeback_value[31:0]);
        idle();
        tick();
    endtask

    task automatic test_call();
        idle();
        for (int l = 0; l < NL; l++) ix_result[l*32 +: 32] = $urandom();
        ix_instruction_valid = 1; ix_thread_idx = 3; ix_is_call = 1; ix_rollback_en = 1;
        ix_pc = 32'h100; ix_rollback_pc = 32'h400; ix_has_dest = 1; ix_dest_reg = 12;
        ix_dest_vector = 1; ix_mask_value = 16'h00f0;
        tick();
        total++;
        if ({wb_writeback_en, wb_writeback_reg, wb_writeback_vector, wb_writeback_mask,
             wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc, wb_perf_instruction_retire} !==
            {1'b1, 5'd31, 1'b0, 16'hffff, 1'b1, 2'd3, 32'h400, 1'b1}) begin
            bad++;
            $display("FAIL call_ctrl got reg=%0d vec=%0b rb=%0b rbpc=%h want 31/0/1/400",
                     wb_writeback_reg, wb_writeback_vector, wb_rollback_en, wb_rollback_pc);
        end
        total++;
        if (wb_writeback_value !== {16{32'h104}}) begin
            bad++;
            $display("FAIL call_link got lane0=%h want 00000104", wb_writeback_value[31:0]);
        end
        $display("call: reg=%0d link=%h rbpc=%h", wb_writeback_reg, wb_writeback_value[31:0],
                 wb_rollback_pc);
        idle();
        repeat (3) tick();
    endtask

    task automatic test_dd_over_ix();
        idle();
        dd_instruction_valid = 1; dd_thread_idx = 2; dd_rollback_en = 1; dd_rollback_pc = 32'h80;
        dd_has_dest = 1; dd_dest_reg = 6;
        ix_instruction_valid = 1; ix_thread_idx = 2; ix_rollback_en = 1; ix_rollback_pc = 32'h200;
        ix_has_dest = 1; ix_dest_reg = 7;
        tick();
        total++;
        if ({wb_writeback_en, wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc, wb_trap,
             wb_perf_instruction_retire} !== {1'b0, 1'b1, 2'd2, 32'h80, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL dd_over_ix got wen=%0b rb=%0b thr=%0d pc=%h ret=%0b want 0/1/2/80/0",
                     wb_writeback_en, wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc,
                     wb_perf_instruction_retire);
        end
        $display("dd_over_ix: rbpc=%h wen=%0b", wb_rollback_pc, wb_writeback_en);
        idle();
        repeat (3) tick();
    endtask

    task automatic test_shadow();
        idle();
        ix_instruction_valid = 1; ix_thread_idx = 0; ix_rollback_en = 1; ix_rollback_pc = 32'h300;
        tick();
        total++;
        if ({wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc} !== {1'b1, 2'd0, 32'h300}) begin
            bad++;
            $display("FAIL shadow_rb got rb=%0b pc=%h want 1/300", wb_rollback_en, wb_rollback_pc);
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            ix_instruction_valid = 1; ix_thread_idx = 0; ix_has_dest = 1; ix_dest_reg = 9;
            ix_result[31:0] = 32'h900 + k;
            dd_instruction_valid = 1; dd_thread_idx = 1; dd_has_dest = (k < 2); dd_dest_reg = 10;
            dd_result[31:0] = 32'ha00 + k;
            tick();
            total++;
            if (k < 2) begin
                if ({wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg,
                     wb_perf_instruction_retire, wb_writeback_value[31:0]} !==
                    {1'b1, 2'd1, 5'd10, 1'b1, 32'ha00 + 32'(k)}) begin
                    bad++;
                    $display("FAIL shadow_cycle%0d got thr=%0d reg=%0d val=%h want thr1 reg10",
                             k, wb_writeback_thread_idx, wb_writeback_reg, wb_writeback_value[31:0]);
                end
            end else begin
                if ({wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg,
                     wb_perf_instruction_retire, wb_writeback_value[31:0]} !==
                    {1'b1, 2'd0, 5'd9, 1'b1, 32'h902}) begin
                    bad++;
                    $display("FAIL shadow_release got thr=%0d reg=%0d val=%h want thr0 reg9 902",
                             wb_writeback_thread_idx, wb_writeback_reg, wb_writeback_value[31:0]);
                end
            end
            $display("shadow %0d: wen=%0b thr=%0d reg=%0d", k, wb_writeback_en,
                     wb_writeback_thread_idx, wb_writeback_reg);
        end
        idle();
        tick();
    endtask

    task automatic test_faults();
        idle();
        cr_trap_handler = 32'h1000;
        ix_instruction_valid = 1; ix_thread_idx = 1; ix_privileged_op_fault = 1; ix_pc = 32'h500;
        ix_has_dest = 1; ix_dest_reg = 3;
        tick();
        total++;
        if ({wb_writeback_en, wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc, wb_trap,
             wb_trap_cause, wb_trap_pc, wb_perf_instruction_retire} !==
            {1'b0, 1'b1, 2'd1, 32'h1000, 1'b1, 2'd1, 32'h500, 1'b0}) begin
            bad++;
            $display("FAIL priv_fault got trap=%0b cause=%0d tpc=%h rbpc=%h wen=%0b",
                     wb_trap, wb_trap_cause, wb_trap_pc, wb_rollback_pc, wb_writeback_en);
        end
        $display("priv_fault: cause=%0d tpc=%h", wb_trap_cause, wb_trap_pc);
        idle();
        repeat (3) tick();
        dd_instruction_valid = 1; dd_thread_idx = 2; dd_fault = 1; dd_pc = 32'h640;
        ix_instruction_valid = 1; ix_thread_idx = 2; ix_has_dest = 1; ix_dest_reg = 8;
        tick();
        total++;
        if ({wb_writeback_en, wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc, wb_trap,
             wb_trap_cause, wb_trap_pc, wb_perf_instruction_retire} !==
            {1'b0, 1'b1, 2'd2, 32'h1000, 1'b1, 2'd2, 32'h640, 1'b0}) begin
            bad++;
            $display("FAIL dd_fault got trap=%0b cause=%0d tpc=%h rbpc=%h wen=%0b",
                     wb_trap, wb_trap_cause, wb_trap_pc, wb_rollback_pc, wb_writeback_en);
        end
        $display("dd_fault: cause=%0d tpc=%h", wb_trap_cause, wb_trap_pc);
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_shadow();
        idle();
        ix_instruction_valid = 1; ix_thread_idx = 2; ix_rollback_en = 1; ix_rollback_pc = 32'h700;
        tick();
        idle();
        dd_instruction_valid = 1; dd_thread_idx = 0; dd_has_dest = 1; dd_dest_reg = 3;
        dd_result[31:0] = 32'h33;
        tick();
        total++;
        if (wb_writeback_en !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_write got=%0b want=1", wb_writeback_en);
        end
        idle();
        reset = 1;
        #2;
        total++;
        if ({obs_ctrl(), wb_writeback_value} !== '0) begin
            bad++;
            $display("FAIL async_reset got ctrl=%h want all zero", obs_ctrl());
        end
        #1;
        reset = 0;
        model_clear();
        ix_instruction_valid = 1; ix_thread_idx = 2; ix_has_dest = 1; ix_dest_reg = 4;
        ix_result[31:0] = 32'habcd;
        tick();
        total++;
        if ({wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg,
             wb_writeback_value[31:0]} !== {1'b1, 2'd2, 5'd4, 32'habcd}) begin
            bad++;
            $display("FAIL post_reset_write got en=%0b thr=%0d reg=%0d val=%h want 1/2/4/abcd",
                     wb_writeback_en, wb_writeback_thread_idx, wb_writeback_reg,
                     wb_writeback_value[31:0]);
        end
        $display("reset_mid_shadow: wen=%0b thr=%0d", wb_writeback_en, wb_writeback_thread_idx);
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int l = 0; l < NL; l++) begin
                ix_result[l*32 +: 32] = $urandom();
                dd_result[l*32 +: 32] = $urandom();
            end
            ix_instruction_valid   = ($urandom_range(0, 3) != 0);
            ix_thread_idx          = 2'($urandom_range(0, 3));
            ix_has_dest            = $urandom_range(0, 1) == 1;
            ix_dest_reg            = 5'($urandom());
            ix_dest_vector         = $urandom_range(0, 1) == 1;
            ix_mask_value          = 16'($urandom());
            ix_pc                  = $urandom() & 32'hffff_fffc;
            ix_is_call             = ($urandom_range(0, 7) == 0);
            ix_rollback_en         = ($urandom_range(0, 3) == 0) || ix_is_call;
            ix_rollback_pc         = $urandom();
            ix_privileged_op_fault = ($urandom_range(0, 7) == 0);
            dd_instruction_valid   = ($urandom_range(0, 3) != 0);
            dd_thread_idx          = 2'($urandom_range(0, 3));
            dd_has_dest            = $urandom_range(0, 1) == 1;
            dd_dest_reg            = 5'($urandom());
            dd_dest_vector         = $urandom_range(0, 1) == 1;
            dd_mask_value          = 16'($urandom());
            dd_pc                  = $urandom();
            dd_rollback_en         = ($urandom_range(0, 5) == 0);
            dd_rollback_pc         = $urandom();
            dd_fault               = ($urandom_range(0, 9) == 0);
            cr_trap_handler        = $urandom();
            // Keep within what the scheduler can issue: one write and one rollback per cycle.
            if (dd_instruction_valid) begin
                if (dd_has_dest) begin
                    ix_has_dest = 0; ix_is_call = 0;
                end
                if ((dd_rollback_en || dd_fault) && dd_thread_idx != ix_thread_idx) begin
                    ix_rollback_en = 0; ix_is_call = 0; ix_privileged_op_fault = 0;
                end
            end
            tick();
            total++;
            if (obs_ctrl() !== exp_ctrl()) begin
                bad++;
                $display("FAIL rnd_ctrl cycle %0d got=%h want=%h", n, obs_ctrl(), exp_ctrl());
            end
            total++;
            if (wb_writeback_value !== e_wval) begin
                bad++;
                $display("FAIL rnd_value cycle %0d got lane0=%h want lane0=%h", n,
                         wb_writeback_value[31:0], e_wval[31:0]);
            end
            $display("rnd %0d: wen=%0b rb=%0b trap=%0b ret=%0b", n, wb_writeback_en,
                     wb_rollback_en, wb_trap, wb_perf_instruction_retire);
        end
        reset = 0;
        idle();
        tick();
    endtask

    initial begin
        model_clear();
        idle();
        test_reset();
        test_scalar_add();
        test_call();
        test_dd_over_ix();
        test_shadow();
        test_faults();
        test_reset_mid_shadow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
